hilo_div_ctrl: RTL and testbench

//  Multi-cycle sequencer for the HI/LO divide path. It accepts DIV/DIVU from the EX stage
//  and stalls the pipeline while a WIDTH-step radix-2 restoring division runs. It then

---
 rtl/hilo_div_ctrl_pkg.sv | 18 +
 rtl/hilo_div_ctrl_core.sv | 95 +++++++++
 rtl/hilo_div_ctrl.sv | 105 ++++++++++
 tb/tb_hilo_div_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide path.
//   DIV_IDLE/DIV_BUSY/DIV_DONE : sequencer state encodings (2-bit)
//   DIV_WIDTH                  : default operand/result width
//   DIV_CNT_W                  : step-counter width for DIV_WIDTH steps
//   EXE_DIV/EXE_DIVU           : funct codes decoded upstream in EX
package hilo_div_ctrl_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    localparam logic [5:0] EXE_DIV  = 6'b011010;
    localparam logic [5:0] EXE_DIVU = 6'b011011;

endpackage

// File: rtl/hilo_div_ctrl_core.sv
// div_radix2_core: radix-2 restoring divider datapath.
// Ports:
//   clk, resetn       clock, async active-low reset
//   i_load            capture |opa|, |opb|, sign flags and the raw dividend
//   i_step            commit one restoring step into rem/quo
//   i_fix_sign        final step: outputs carry the sign-corrected result
//   i_signed_div      1 = signed operands (DIV), 0 = unsigned (DIVU)
//   i_opa, i_opb      dividend, divisor
//   o_hi, o_lo        result of the current step (remainder, quotient);
//                     sign-corrected / divide-by-zero substituted when i_fix_sign
module div_radix2_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix_sign,
    input  logic             i_signed_div,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_opa_orig;
    logic             r_sign_a;
    logic             r_sign_b;

    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;

    always_comb begin
        w_sign_a = i_signed_div & i_opa[WIDTH-1];
        w_sign_b = i_signed_div & i_opb[WIDTH-1];
        w_abs_a  = w_sign_a ? ('0 - i_opa) : i_opa;
        w_abs_b  = w_sign_b ? ('0 - i_opb) : i_opb;
    end

    // Partial remainder is always < divisor, so the shifted value fits in
    // WIDTH+1 bits; one extra bit on the subtractor exposes the borrow.
    always_comb begin
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_trial    = {1'b0, w_shift} - {2'b00, r_div};
        w_borrow   = w_trial[WIDTH+1];
        w_rem_step = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_quo_step = {r_quo[WIDTH-2:0], ~w_borrow};
    end

    always_comb begin
        o_hi = w_rem_step;
        o_lo = w_quo_step;
        if (i_fix_sign) begin
            if (r_div == '0) begin
                o_hi = r_opa_orig;
                o_lo = '1;
            end else begin
                if (r_sign_a ^ r_sign_b) o_lo = '0 - w_quo_step;
                if (r_sign_a)            o_hi = '0 - w_rem_step;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_opa_orig <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
        end else if (i_load) begin
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_div      <= w_abs_b;
            r_opa_orig <= i_opa;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
        end else if (i_step) begin
            r_rem      <= w_rem_step;
            r_quo      <= w_quo_step;
        end
    end

endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: multi-cycle sequencer for DIV/DIVU on the HI/LO path.
// Ports:
//   clk, resetn    clock, async active-low reset
//   start          EX holds DIV/DIVU (level, held while stalled)
//   signed_div     1 = DIV, 0 = DIVU
//   flush          annul the EX instruction
//   opa, opb       dividend (rs), divisor (rt)
//   stall          freeze IF..EX this cycle
//   result_valid   one-cycle strobe: write HI/LO
//   hi_out, lo_out remainder, quotient (held until the next completion)
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_busy;
    logic             w_last;
    logic             w_step;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;

    always_comb begin
        w_accept = (r_state == DIV_IDLE) & start & ~flush;
        w_busy   = (r_state == DIV_BUSY);
        w_step   = w_busy & ~flush;
        w_last   = w_busy & (r_count == LAST_STEP);
    end

    div_radix2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk          (clk),
        .resetn       (resetn),
        .i_load       (w_accept),
        .i_step       (w_step),
        .i_fix_sign   (w_last),
        .i_signed_div (signed_div),
        .i_opa        (opa),
        .i_opb        (opb),
        .o_hi         (w_core_hi),
        .o_lo         (w_core_lo)
    );

    // Gated by resetn so a held start cannot stall the pipe during reset.
    assign stall        = resetn & (w_accept | w_busy);
    assign result_valid = (r_state == DIV_DONE) & ~flush;
    assign hi_out       = r_hi;
    assign lo_out       = r_lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_state <= DIV_BUSY;
                        r_count <= '0;
                    end
                end
                DIV_BUSY: begin
                    if (flush) begin
                        r_state <= DIV_IDLE;
                    end else if (w_last) begin
                        // Core output already carries the final step with sign fix.
                        r_state <= DIV_DONE;
                        r_hi    <= w_core_hi;
                        r_lo    <= w_core_lo;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                // start is ignored here: the finished instruction is still in EX.
                DIV_DONE: r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
module tb_hilo_div_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        flush;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        stall;
    logic        result_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        q[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    hilo_div_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .signed_div   (signed_div),
        .flush        (flush),
        .opa          (opa),
        .opb          (opb),
        .stall        (stall),
        .result_valid (result_valid),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: plain integer division with MIPS-style truncation.
    function automatic exp_t ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int sa, sb;
        if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else if (!sgn) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            e.lo = 32'(sa / sb);
            e.hi = 32'(sa % sb);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got hi=%h lo=%h expected no result", hi_out, lo_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_hi", {32'd0, hi_out}, {32'd0, e.hi});
                chk("result_lo", {32'd0, lo_out}, {32'd0, e.lo});
                last_hi = e.hi;
                last_lo = e.lo;
            end
        end
    end

    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output int vcyc);
        int stalls = 0;
        int lat = -1;
        bit seen = 0;
        vcyc = -1;
        @(posedge clk); #1;
        start = 1'b1; signed_div = sgn; opa = a; opb = b; flush = 1'b0;
        q.push_back(ref_div(sgn, a, b));
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (result_valid) begin
                seen = 1;
                lat = i;
                vcyc = cyc;
            end
            if (i == 1) begin
                opa = $urandom;
                opb = $urandom;
            end
        end
        chk("latency", 64'(lat), 64'd33);
        chk("stall_cycles", 64'(stalls), 64'd33);
        if (!hold) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("idle_after_done", {62'd0, stall, result_valid}, 64'd0);
        end
    endtask

    initial begin
        int v1, v2, k;
        resetn = 1'b0; start = 1'b1; signed_div = 1'b0; flush = 1'b0; opa = 32'd7; opb = 32'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {30'd0, stall, result_valid, hi_out}, 64'd0);
        chk("reset_lo", {32'd0, lo_out}, 64'd0);
        start = 1'b0;
        resetn = 1'b1;

        do_div(0, 32'd7, 32'd2, 0, v1);
        do_div(1, -32'sd7, 32'd2, 0, v1);
        do_div(1, 32'd7, -32'sd2, 0, v1);
        do_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, v1);
        do_div(0, 32'hFFFF_FFFF, 32'd1, 0, v1);
        do_div(0, 32'd5, 32'd0, 0, v1);
        do_div(1, -32'sd5, 32'd0, 0, v1);

        // Flush during BUSY
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
        q.push_back(ref_div(0, 32'd100, 32'd7));
        for (int i = 0; i <= 10; i++) @(negedge clk);
        chk("stall_before_flush", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        chk("stall_after_flush", {63'd0, stall}, 64'd0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid) k++;
        end
        chk("flush_no_valid", 64'(k), 64'd0);
        chk("flush_hold_hi", {32'd0, hi_out}, {32'd0, last_hi});
        chk("flush_hold_lo", {32'd0, lo_out}, {32'd0, last_lo});
        do_div(0, 32'd9, 32'd3, 0, v1);

        // Async reset mid-operation
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b1; opa = 32'd1234; opb = 32'd5;
        q.push_back(ref_div(1, 32'd1234, 32'd5));
        for (int i = 0; i <= 20; i++) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("reset_mid_ctl", {62'd0, stall, result_valid}, 64'd0);
        chk("reset_mid_out", {hi_out, lo_out}, 64'd0);
        void'(q.pop_back());
        last_hi = '0; last_lo = '0;
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {63'd0, stall}, 64'd0);

        // Back-to-back
        do_div(1, 32'd100, -32'sd7, 1, v1);
        do_div(0, 32'd1000, 32'd13, 0, v2);
        chk("b2b_spacing", 64'(v2 - v1), 64'd34);

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            logic [31:0] a, b;
            bit sgn, hold;
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            hold = (n < 19) && ($urandom_range(0, 1) == 1);
            do_div(sgn, a, b, hold, v1);
        end

        // Flush together with start in IDLE
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; opa = 32'd50; opb = 32'd5;
        @(negedge clk);
        chk("idle_flush_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid || stall) k++;
        end
        chk("idle_flush_quiet", 64'(k), 64'd0);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
